// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master (fetch, LSU) arbiter onto one req/gnt/rvalid memory port
// Holds selection until grant and returns in-order responses via a small ID FIFO.
module mem_port_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter bit RR_MODE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic [2:0]  outst_o,
  output logic        err_o
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [MAX_OUTST-1:0] fifo_q, fifo_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]           outst_q, outst_d;
  logic                 lock_valid_q, lock_valid_d;
  logic                 lock_id_q, lock_id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 err_q, err_d;

  logic sel, sel_req, can_issue, grant, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTST - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    can_issue = (outst_q < 3'(MAX_OUTST));
    if (lock_valid_q)             sel = lock_id_q;
    else if (m0_req_i && m1_req_i) sel = RR_MODE ? ~last_grant_q : 1'b1;
    else                           sel = m1_req_i;
    sel_req = sel ? m1_req_i : m0_req_i;
    // Outputs are combinational from inputs, so reset gates them explicitly.
    s_req_o = can_issue & sel_req & ~reset;
    grant   = s_req_o & s_gnt_i;
    pop     = s_rvalid_i & (outst_q != 3'd0) & ~reset;
    head    = fifo_q[rd_ptr_q];
  end

  always_comb begin
    s_addr_o    = '0;
    s_we_o      = 1'b0;
    s_be_o      = '0;
    s_wdata_o   = '0;
    if (s_req_o) begin
      s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      s_we_o    = sel ? m1_we_i    : 1'b0;
      s_be_o    = sel ? m1_be_i    : 4'b1111;
      s_wdata_o = sel ? m1_wdata_i : 32'd0;
    end
    m0_gnt_o    = grant & ~sel;
    m1_gnt_o    = grant & sel;
    m0_rvalid_o = pop & ~head;
    m1_rvalid_o = pop & head;
    m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'd0;
    m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'd0;
    outst_o     = outst_q;
    err_o       = err_q;
  end

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    outst_d      = outst_q;
    last_grant_d = last_grant_q;
    // A waiting request pins the selection; a dropped request releases it.
    lock_valid_d = s_req_o & ~s_gnt_i;
    lock_id_d    = lock_valid_d ? sel : lock_id_q;
    err_d        = err_q | (s_rvalid_i & (outst_q == 3'd0));
    if (grant) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      last_grant_d     = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({grant, pop})
      2'b10:   outst_d = outst_q + 3'd1;
      2'b01:   outst_d = outst_q - 3'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      outst_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      outst_q      <= outst_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m1_we, s_gnt, s_rvalid;
  logic        rr_m0_req, rr_m1_req;
  logic [31:0] m0_addr, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m1_be;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_req, s_we, err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [2:0]  outst;

  logic        r_m0_gnt, r_m0_rvalid, r_m1_gnt, r_m1_rvalid, r_s_req, r_s_we, r_err;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
  logic [3:0]  r_s_be;
  logic [2:0]  r_outst;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;
  typedef struct {
    logic        m;
    logic [31:0] data;
  } rv_t;

  gnt_t exp_g[$];
  rv_t  exp_r[$];
  logic exp_rr[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTST(2), .RR_MODE(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outst_o(outst), .err_o(err)
  );

  mem_port_arbiter #(.MAX_OUTST(4), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_req_i(rr_m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(r_m0_gnt),
    .m0_rvalid_o(r_m0_rvalid), .m0_rdata_o(r_m0_rdata),
    .m1_req_i(rr_m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(r_m1_gnt), .m1_rvalid_o(r_m1_rvalid), .m1_rdata_o(r_m1_rdata),
    .s_req_o(r_s_req), .s_addr_o(r_s_addr), .s_we_o(r_s_we), .s_be_o(r_s_be), .s_wdata_o(r_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outst_o(r_outst), .err_o(r_err)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_g(logic m, logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
    gnt_t g;
    g.m = m; g.addr = a; g.we = we; g.be = be; g.wdata = wd;
    exp_g.push_back(g);
  endfunction

  function automatic void push_r(logic m, logic [31:0] d);
    rv_t r;
    r.m = m; r.data = d;
    exp_r.push_back(r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    gnt_t g;
    rv_t  r;
    logic e;
    if (m0_gnt || m1_gnt) begin
      chk("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
      if (exp_g.size() == 0) chk("unexpected_gnt", {31'd0, m0_gnt | m1_gnt}, 32'd0);
      else begin
        g = exp_g.pop_front();
        chk("gnt_id", {31'd0, m1_gnt}, {31'd0, g.m});
        chk("s_addr", s_addr, g.addr);
        chk("s_we", {31'd0, s_we}, {31'd0, g.we});
        chk("s_be", {28'd0, s_be}, {28'd0, g.be});
        chk("s_wdata", s_wdata, g.wdata);
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      chk("rvalid_onehot", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
      if (exp_r.size() == 0) chk("unexpected_rvalid", {31'd0, m0_rvalid | m1_rvalid}, 32'd0);
      else begin
        r = exp_r.pop_front();
        chk("rvalid_id", {31'd0, m1_rvalid}, {31'd0, r.m});
        chk("rdata", r.m ? m1_rdata : m0_rdata, r.data);
        chk("rdata_other_zero", r.m ? m0_rdata : m1_rdata, 32'd0);
      end
    end
    if (r_m0_gnt || r_m1_gnt) begin
      if (exp_rr.size() == 0) chk("rr_unexpected_gnt", {31'd0, r_m0_gnt | r_m1_gnt}, 32'd0);
      else begin
        e = exp_rr.pop_front();
        chk("rr_gnt_id", {31'd0, r_m1_gnt}, {31'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b1; m1_req = 1'b0; m1_we = 1'b0; s_gnt = 1'b1; s_rvalid = 1'b1;
    rr_m0_req = 1'b0; rr_m1_req = 1'b0;
    m0_addr = 32'h10; m1_addr = '0; m1_wdata = '0; m1_be = 4'hf; s_rdata = 32'h1;
    @(negedge clk);
    chk("rst_s_req", {31'd0, s_req}, 32'd0);
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_outst", {29'd0, outst}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
    cyc();
    reset = 1'b0;

    // single fetch
    cyc();
    m0_req = 1'b1; m0_addr = 32'h100; s_gnt = 1'b1;
    push_g(1'b0, 32'h100, 1'b0, 4'hf, 32'd0);
    @(negedge clk); chk("t1_outst0", {29'd0, outst}, 32'd0);
    cyc(); m0_req = 1'b0; s_gnt = 1'b0;
    @(negedge clk); chk("t1_outst1", {29'd0, outst}, 32'd1);
    cyc(); s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; push_r(1'b0, 32'hDEADBEEF);
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t1_outst_end", {29'd0, outst}, 32'd0);

    // fixed priority, LSU first, in-order return
    cyc();
    m0_req = 1'b1; m0_addr = 32'h200;
    m1_req = 1'b1; m1_addr = 32'h300; m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'hCAFE0000;
    s_gnt = 1'b1;
    push_g(1'b1, 32'h300, 1'b1, 4'b0011, 32'hCAFE0000);
    cyc(); m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'hf;
    push_g(1'b0, 32'h200, 1'b0, 4'hf, 32'd0);
    cyc(); m0_req = 1'b0; s_gnt = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h11111111; push_r(1'b1, 32'h11111111);
    @(negedge clk); chk("t2_outst2", {29'd0, outst}, 32'd2);
    cyc(); s_rdata = 32'h22222222; push_r(1'b0, 32'h22222222);
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t2_outst_end", {29'd0, outst}, 32'd0);

    // lock holds fetch while slave stalls
    cyc(); m0_req = 1'b1; m0_addr = 32'h400; s_gnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_s_req", {31'd0, s_req}, 32'd1);
      chk("t4_s_addr", s_addr, 32'h400);
      cyc();
    end
    m1_req = 1'b1; m1_addr = 32'h500; m1_wdata = 32'h12345678;
    @(negedge clk); chk("t4_locked_addr", s_addr, 32'h400);
    cyc(); s_gnt = 1'b1; push_g(1'b0, 32'h400, 1'b0, 4'hf, 32'd0);
    cyc(); m0_req = 1'b0; push_g(1'b1, 32'h500, 1'b0, 4'hf, 32'h12345678);
    cyc(); m1_req = 1'b0; s_gnt = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h44; push_r(1'b0, 32'h44);
    cyc(); s_rdata = 32'h55; push_r(1'b1, 32'h55);
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t4_outst_end", {29'd0, outst}, 32'd0);

    // outstanding limit
    cyc(); m0_req = 1'b1; m0_addr = 32'h600; s_gnt = 1'b1; push_g(1'b0, 32'h600, 1'b0, 4'hf, 32'd0);
    cyc(); m0_addr = 32'h604; push_g(1'b0, 32'h604, 1'b0, 4'hf, 32'd0);
    cyc(); m0_addr = 32'h608;
    @(negedge clk);
    chk("t5_full_s_req", {31'd0, s_req}, 32'd0);
    chk("t5_full_outst", {29'd0, outst}, 32'd2);
    cyc(); s_rvalid = 1'b1; s_rdata = 32'hA; push_r(1'b0, 32'hA);
    @(negedge clk); chk("t5_pop_no_free", {31'd0, s_req}, 32'd0);
    cyc(); s_rdata = 32'hB; push_r(1'b0, 32'hB); push_g(1'b0, 32'h608, 1'b0, 4'hf, 32'd0);
    @(negedge clk); chk("t5_resume", {31'd0, s_req}, 32'd1);
    cyc(); m0_req = 1'b0; s_gnt = 1'b0; s_rdata = 32'hC; push_r(1'b0, 32'hC);
    @(negedge clk); chk("t5_pushpop_outst", {29'd0, outst}, 32'd1);
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t5_outst_end", {29'd0, outst}, 32'd0);

    // stray rvalid and reset mid-transaction
    cyc(); s_rvalid = 1'b1; s_rdata = 32'h5A5A5A5A;
    @(negedge clk); chk("t6_err_before", {31'd0, err}, 32'd0);
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t6_err_set", {31'd0, err}, 32'd1);
    cyc();
    @(negedge clk); chk("t6_err_hold", {31'd0, err}, 32'd1);
    cyc(); m0_req = 1'b1; m0_addr = 32'h700; s_gnt = 1'b1; push_g(1'b0, 32'h700, 1'b0, 4'hf, 32'd0);
    cyc(); m0_req = 1'b0; s_gnt = 1'b0;
    @(negedge clk); chk("t6_outst1", {29'd0, outst}, 32'd1);
    m0_req = 1'b1; reset = 1'b1;
    #1;
    chk("t6_rst_outst", {29'd0, outst}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    chk("t6_rst_s_req", {31'd0, s_req}, 32'd0);
    cyc(); reset = 1'b0; m0_req = 1'b0;
    cyc(); s_rvalid = 1'b1; s_rdata = 32'h77;
    cyc(); s_rvalid = 1'b0;
    @(negedge clk); chk("t6_stale_err", {31'd0, err}, 32'd1);

    // round-robin vs fixed priority under continuous contention
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc();
    m0_req = 1'b1; m1_req = 1'b1; rr_m0_req = 1'b1; rr_m1_req = 1'b1;
    m0_addr = 32'h800; m1_addr = 32'h900; m1_wdata = 32'd0; s_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rr.push_back((k % 2) == 0);
      if (k < 2) push_g(1'b1, 32'h900, 1'b0, 4'hf, 32'd0);
      @(negedge clk);
      if (k >= 2) chk("t3_fixed_stall", {31'd0, s_req}, 32'd0);
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0; rr_m0_req = 1'b0; rr_m1_req = 1'b0; s_gnt = 1'b0;
    reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc();

    chk("left_exp_gnt", exp_g.size(), 32'd0);
    chk("left_exp_rvalid", exp_r.size(), 32'd0);
    chk("left_exp_rr", exp_rr.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
